snake_engine: RTL and testbench

Game-state core of the snake display path. Holds the snake segment list on the 40×30 grid of 16×16-pixel cells and advances it one cell per `move_en` tick. Detects apple consumption and wall or self collisions. Answers the raster's per-pixel query with a 2-bit cell code on `snake`, which the VGA colour stage consumes alongside `apple_x`/`apple_y`.

---
 rtl/snake_pkg.sv | 37 +++
 rtl/snake_cell_match.sv | 29 ++
 rtl/snake_engine.sv | 176 +++++++++++++++++
 tb/tb_snake_engine.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game-state core.
package snake_pkg;

  typedef enum logic [1:0] {NONE = 2'b00, HEAD = 2'b01, BODY = 2'b10, WALL = 2'b11} cell_e;
  typedef enum logic [1:0] {UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11} dir_e;
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DEAD = 2'b10} state_e;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int CELL_SHIFT = 4;

  localparam logic [5:0] LAST_COL = 6'(GRID_W - 1);
  localparam logic [4:0] LAST_ROW = 5'(GRID_H - 1);

  localparam logic [5:0] INIT_X   = 6'd20;
  localparam logic [4:0] INIT_Y   = 5'd15;
  localparam int         INIT_LEN = 3;

  // Opposite directions differ only in bit 0 within the same axis.
  function automatic dir_e reverse_dir(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

  function automatic logic is_wall(input logic [5:0] x, input logic [4:0] y);
    return (x == '0) || (x == LAST_COL) || (y == '0) || (y == LAST_ROW);
  endfunction

  // Initial snake lies horizontally, head rightmost; unused slots are zeroed.
  function automatic logic [5:0] init_seg_x(input int i);
    return (i < INIT_LEN) ? INIT_X - 6'(i) : '0;
  endfunction

  function automatic logic [4:0] init_seg_y(input int i);
    return (i < INIT_LEN) ? INIT_Y : '0;
  endfunction

endpackage

// File: rtl/snake_cell_match.sv
// Combinational match of one grid cell against the valid part of the segment list.
module snake_cell_match
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [5:0]                x,
  input  logic [4:0]                y,
  input  logic [MAX_LEN-1:0][5:0]   seg_x,
  input  logic [MAX_LEN-1:0][4:0]   seg_y,
  input  logic [LEN_W-1:0]          len,
  input  logic                      excl_tail,
  output logic                      hit_head,
  output logic                      hit_body
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit_head = (len != '0) && (seg_x[0] == x) && (seg_y[0] == y);
    hit_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i < int'(len)) && !(excl_tail && (i == int'(len) - 1)) &&
          (seg_x[i] == x) && (seg_y[i] == y))
        hit_body = 1'b1;
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game-state core: segment list, movement, collisions and per-pixel cell query.
// Define SNAKE_WRAP_EN to remove the border walls and wrap the head around the grid.
module snake_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           move_en,
  input  logic [1:0]                     dir,
  input  logic [5:0]                     apple_x,
  input  logic [4:0]                     apple_y,
  input  logic [9:0]                     x_pos,
  input  logic [9:0]                     y_pos,
  output logic [1:0]                     snake,
  output logic                           apple_eaten,
  output logic                           game_over,
  output logic [$clog2(MAX_LEN+1)-1:0]   snake_len
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e                 state, next_state;
  dir_e                   cur_dir, req_dir, eff_dir;
  logic [MAX_LEN-1:0][5:0] seg_x;
  logic [MAX_LEN-1:0][4:0] seg_y;
  logic [5:0]             new_x, qx;
  logic [4:0]             new_y, qy;
  logic                   grow, collide, wall_hit, do_move, do_init;
  logic                   col_head, col_body, q_head, q_body, q_in_range;
  cell_e                  q_code;

  assign req_dir = dir_e'(dir);
  assign eff_dir = (req_dir == reverse_dir(cur_dir)) ? cur_dir : req_dir;

  always_comb begin
    new_x = seg_x[0];
    new_y = seg_y[0];
    unique case (eff_dir)
`ifdef SNAKE_WRAP_EN
      UP:    new_y = (seg_y[0] == '0)       ? LAST_ROW : seg_y[0] - 5'd1;
      DOWN:  new_y = (seg_y[0] == LAST_ROW) ? '0       : seg_y[0] + 5'd1;
      LEFT:  new_x = (seg_x[0] == '0)       ? LAST_COL : seg_x[0] - 6'd1;
      RIGHT: new_x = (seg_x[0] == LAST_COL) ? '0       : seg_x[0] + 6'd1;
`else
      UP:    new_y = seg_y[0] - 5'd1;
      DOWN:  new_y = seg_y[0] + 5'd1;
      LEFT:  new_x = seg_x[0] - 6'd1;
      RIGHT: new_x = seg_x[0] + 6'd1;
`endif
    endcase
  end

  assign grow = (new_x == apple_x) && (new_y == apple_y);

`ifdef SNAKE_WRAP_EN
  assign wall_hit = 1'b0;
`else
  assign wall_hit = is_wall(new_x, new_y);
`endif

  // The tail vacates its cell on a non-growing move, so the head may follow it.
  snake_cell_match #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_collide_match (
    .x         (new_x),
    .y         (new_y),
    .seg_x     (seg_x),
    .seg_y     (seg_y),
    .len       (snake_len),
    .excl_tail (~grow),
    .hit_head  (col_head),
    .hit_body  (col_body)
  );

  assign collide = wall_hit | col_head | col_body;

  always_comb begin
    next_state = state;
    do_move    = 1'b0;
    do_init    = 1'b0;
    unique case (state)
      IDLE: if (start) next_state = PLAY;
      PLAY: begin
        if (move_en) begin
          if (collide) next_state = DEAD;
          else         do_move    = 1'b1;
        end
      end
      DEAD: begin
        if (start) begin
          next_state = IDLE;
          do_init    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  assign game_over = (state == DEAD);

  // NOTE: the segment store is reset explicitly because it must come up holding the initial snake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_seg_x(i);
        seg_y[i] <= init_seg_y(i);
      end
      snake_len   <= LEN_W'(INIT_LEN);
      cur_dir     <= RIGHT;
      apple_eaten <= 1'b0;
    end else begin
      apple_eaten <= do_move & grow;
      if (do_init) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          seg_x[i] <= init_seg_x(i);
          seg_y[i] <= init_seg_y(i);
        end
        snake_len <= LEN_W'(INIT_LEN);
        cur_dir   <= RIGHT;
      end else begin
        if ((state == PLAY) && move_en) cur_dir <= eff_dir;
        if (do_move) begin
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= new_x;
          seg_y[0] <= new_y;
          if (grow && (snake_len != LEN_W'(MAX_LEN))) snake_len <= snake_len + 1'b1;
        end
      end
    end
  end

  assign qx         = x_pos[CELL_SHIFT +: 6];
  assign qy         = y_pos[CELL_SHIFT +: 5];
  assign q_in_range = (x_pos < 10'd640) && (y_pos < 10'd480);

  snake_cell_match #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_query_match (
    .x         (qx),
    .y         (qy),
    .seg_x     (seg_x),
    .seg_y     (seg_y),
    .len       (snake_len),
    .excl_tail (1'b0),
    .hit_head  (q_head),
    .hit_body  (q_body)
  );

  always_comb begin
    q_code = NONE;
    if (q_in_range) begin
`ifdef SNAKE_WRAP_EN
      if      (q_head) q_code = HEAD;
      else if (q_body) q_code = BODY;
`else
      if      (is_wall(qx, qy)) q_code = WALL;
      else if (q_head)          q_code = HEAD;
      else if (q_body)          q_code = BODY;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) snake <= 2'b00;
    else        snake <= q_code;
  end

endmodule

// File: tb/tb_snake_engine.sv
// Directed self-checking bench for snake_engine (wall and SNAKE_WRAP_EN builds).
module tb_snake_engine;

  localparam logic [1:0] D_UP = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_RIGHT = 2'b11;
  localparam logic [1:0] C_NONE = 2'b00, C_HEAD = 2'b01, C_BODY = 2'b10;
`ifdef SNAKE_WRAP_EN
  localparam logic [1:0] C_BORDER = 2'b00;
`else
  localparam logic [1:0] C_BORDER = 2'b11;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       move_en = 1'b0;
  logic [1:0] dir = 2'b11;
  logic [5:0] apple_x = 6'd5;
  logic [4:0] apple_y = 5'd5;
  logic [9:0] x_pos = 10'd1023;
  logic [9:0] y_pos = 10'd1023;
  logic [1:0] snake;
  logic       apple_eaten;
  logic       game_over;
  logic [4:0] snake_len;

  int total = 0;
  int bad   = 0;

  snake_engine #(.MAX_LEN(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .move_en     (move_en),
    .dir         (dir),
    .apple_x     (apple_x),
    .apple_y     (apple_y),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .snake       (snake),
    .apple_eaten (apple_eaten),
    .game_over   (game_over),
    .snake_len   (snake_len)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic query_px(input string tag, input int px, input int py, input logic [1:0] exp);
    x_pos = 10'(px);
    y_pos = 10'(py);
    tick();
    check(tag, 32'(snake), 32'(exp));
  endtask

  task automatic query(input string tag, input int cx, input int cy, input logic [1:0] exp);
    query_px(tag, cx * 16 + 8, cy * 16 + 8, exp);
  endtask

  task automatic mv(input logic [1:0] d);
    dir     = d;
    move_en = 1'b1;
    tick();
    move_en = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    // Reset values and the initial snake as seen by the pixel query.
    reset = 1'b0;
    tick();
    tick();
    check("rst_snake", 32'(snake), 32'(C_NONE));
    check("rst_len", 32'(snake_len), 32'd3);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_eaten", 32'(apple_eaten), 32'd0);
    reset = 1'b1;
    tick();
    check("idle_out_of_range", 32'(snake), 32'(C_NONE));
    query_px("q_head_320_240", 320, 240, C_HEAD);
    query_px("q_body_304_240", 304, 240, C_BODY);
    query("q_tail_18_15", 18, 15, C_BODY);
    query("q_empty_17_15", 17, 15, C_NONE);
    query_px("q_corner_0_0", 0, 0, C_BORDER);
    query_px("q_border_right", 624, 240, C_BORDER);
    query_px("q_offscreen_640", 640, 16, C_NONE);
    query_px("q_offscreen_480", 16, 480, C_NONE);

    // Direction latch and reverse rejection.
    press_start();
    check("start_over", 32'(game_over), 32'd0);
    mv(D_UP);
    query("up_head", 20, 14, C_HEAD);
    query("up_neck", 20, 15, C_BODY);
    query("up_tail_dropped", 18, 15, C_NONE);
    mv(D_DOWN);
    query("rev_head", 20, 13, C_HEAD);
    query("rev_body", 20, 14, C_BODY);
    press_start();
    check("start_in_play_over", 32'(game_over), 32'd0);
    check("start_in_play_len", 32'(snake_len), 32'd3);
    query("start_in_play_head", 20, 13, C_HEAD);
    mv(D_LEFT);
    query("left_head", 19, 13, C_HEAD);

    // Apple consumption, then chasing the tail without growth.
    do_reset();
    press_start();
    apple_x = 6'd21;
    apple_y = 5'd15;
    mv(D_RIGHT);
    apple_x = 6'd5;
    apple_y = 5'd5;
    check("eat_pulse", 32'(apple_eaten), 32'd1);
    check("eat_len", 32'(snake_len), 32'd4);
    tick();
    check("eat_pulse_one_clk", 32'(apple_eaten), 32'd0);
    query("eat_head", 21, 15, C_HEAD);
    query("eat_tail_kept", 18, 15, C_BODY);
    mv(D_UP);
    mv(D_LEFT);
    mv(D_DOWN);
    check("chase_over", 32'(game_over), 32'd0);
    check("chase_len", 32'(snake_len), 32'd4);
    query("chase_head", 20, 15, C_HEAD);
    query("chase_body", 20, 14, C_BODY);

    // Self collision with a 5-cell snake, restart through IDLE.
    do_reset();
    press_start();
    apple_x = 6'd21;
    apple_y = 5'd15;
    mv(D_RIGHT);
    apple_x = 6'd22;
    mv(D_RIGHT);
    apple_x = 6'd5;
    apple_y = 5'd5;
    check("grow2_len", 32'(snake_len), 32'd5);
    mv(D_UP);
    mv(D_LEFT);
    check("pre_hit_over", 32'(game_over), 32'd0);
    mv(D_DOWN);
    check("self_hit_over", 32'(game_over), 32'd1);
    check("self_hit_eaten", 32'(apple_eaten), 32'd0);
    check("self_hit_len", 32'(snake_len), 32'd5);
    query("self_hit_frozen", 21, 14, C_HEAD);
    mv(D_RIGHT);
    query("dead_move_ignored", 21, 14, C_HEAD);
    check("dead_still_over", 32'(game_over), 32'd1);
    press_start();
    check("restart_over", 32'(game_over), 32'd0);
    check("restart_len", 32'(snake_len), 32'd3);
    query("restart_head", 20, 15, C_HEAD);
    query("restart_old_gone", 21, 14, C_NONE);
    start   = 1'b1;
    dir     = D_RIGHT;
    move_en = 1'b1;
    tick();
    start   = 1'b0;
    move_en = 1'b0;
    query("idle_move_ignored", 20, 15, C_HEAD);
    mv(D_RIGHT);
    query("play_after_restart", 21, 15, C_HEAD);

    // Right-wall run and reset while DEAD.
    do_reset();
    press_start();
    for (int k = 0; k < 18; k++) mv(D_RIGHT);
    check("run18_over", 32'(game_over), 32'd0);
    mv(D_RIGHT);
`ifdef SNAKE_WRAP_EN
    check("run19_over_wrap", 32'(game_over), 32'd0);
    mv(D_RIGHT);
    check("run20_over_wrap", 32'(game_over), 32'd0);
    query("wrap_head", 0, 15, C_HEAD);
    query("wrap_body", 39, 15, C_BODY);
`else
    check("run19_over", 32'(game_over), 32'd1);
    check("run19_len", 32'(snake_len), 32'd3);
    query("wall_frozen_head", 38, 15, C_HEAD);
    reset = 1'b0;
    #2;
    check("dead_rst_over", 32'(game_over), 32'd0);
    check("dead_rst_len", 32'(snake_len), 32'd3);
    check("dead_rst_snake", 32'(snake), 32'(C_NONE));
    tick();
    reset = 1'b1;
    tick();
    press_start();
    check("post_rst_over", 32'(game_over), 32'd0);
    query("post_rst_head", 20, 15, C_HEAD);
    query("post_rst_old", 38, 15, C_NONE);
    mv(D_RIGHT);
    query("post_rst_move", 21, 15, C_HEAD);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
